// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory read port, branch redirect and the decode valid/ready handshake.
// Signal suffixes are named from the fetch unit's point of view.
interface instr_fetch_unit_if;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;

  modport master (
    output imem_addr_o,
    input  imem_instr_i,
    input  redirect_i,
    input  redirect_pc_i,
    output if_valid_o,
    input  if_ready_i,
    output if_instr_o,
    output if_pc_o
  );

  modport slave (
    input  imem_addr_o,
    output imem_instr_i,
    output redirect_i,
    output redirect_pc_i,
    input  if_valid_o,
    output if_ready_i,
    input  if_instr_o,
    input  if_pc_o
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetches one word per cycle into a small {pc, instr} FIFO; head is visible one cycle after fetch.
// Stalls fetch when full and not popping; a redirect flushes the FIFO and restarts at the target.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  instr_fetch_unit_if.master ifu
);
  localparam int              PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0]     RESET_PC_W = RESET_PC & ~32'h3;
  localparam logic [CW-1:0]   DEPTH_C    = CW'(FIFO_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q    [FIFO_DEPTH];
  logic [31:0]   instr_mem_q [FIFO_DEPTH];
  logic          head_vld;
  logic          push;
  logic          pop;

  assign head_vld = (count_q != '0);
  assign pop      = head_vld & ifu.if_ready_i;
  // A full FIFO may still fetch when the head leaves in the same cycle.
  assign push     = ~ifu.redirect_i & ((count_q < DEPTH_C) | pop);

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (ifu.redirect_i) begin
      pc_d     = ifu.redirect_pc_i & ~32'h3;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC_W;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= pc_q;
        instr_mem_q[wr_ptr_q] <= ifu.imem_instr_i;
      end
    end
  end

  assign ifu.imem_addr_o = pc_q;
  assign ifu.if_valid_o  = head_vld;
  assign ifu.if_instr_o  = head_vld ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign ifu.if_pc_o     = head_vld ? pc_mem_q[rd_ptr_q] : 32'h0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a queue-based fetch model, plus directed scenarios.
module tb_instr_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC0  = 32'h0000_0000;
  localparam logic [31:0] RPC1  = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [63:0] mq[$];
  logic [31:0] mpc;

  instr_fetch_unit_if ifb();
  instr_fetch_unit_if ifw();

  instr_fetch_unit #(.RESET_PC(RPC0), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .ifu  (ifb)
  );

  instr_fetch_unit #(.RESET_PC(RPC1), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk_i(clk),
    .rst_i(rst),
    .ifu  (ifw)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_8113;
      32'h0000_0008: return 32'h0020_81B3;
      32'h0000_001C: return 32'h0002_8C63;
      default:       return a ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign ifb.imem_instr_i = mem_word(ifb.imem_addr_o);
  assign ifw.imem_instr_i = mem_word(ifw.imem_addr_o);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, act, exp);
  endtask

  task automatic check_model();
    logic [63:0] h;
    logic        v;
    v = (mq.size() != 0);
    h = v ? mq[0] : 64'h0;
    chk("valid", {31'h0, ifb.if_valid_o}, {31'h0, v});
    chk("head_pc", ifb.if_pc_o, h[63:32]);
    chk("head_instr", ifb.if_instr_o, h[31:0]);
    chk("imem_addr", ifb.imem_addr_o, mpc);
  endtask

  // Inputs applied now take effect at the next rising edge; the model advances by the same rules.
  task automatic step(input logic r, input logic rd, input logic [31:0] tgt);
    int sz;
    logic pop;
    ifb.if_ready_i = r;  ifb.redirect_i = rd;  ifb.redirect_pc_i = tgt;
    ifw.if_ready_i = r;  ifw.redirect_i = rd;  ifw.redirect_pc_i = tgt;
    sz  = mq.size();
    pop = (sz != 0) && r;
    if (rd) begin
      mq.delete();
      mpc = tgt & ~32'h3;
    end else begin
      if (pop) void'(mq.pop_front());
      if (sz < DEPTH || pop) begin
        mq.push_back({mpc, mem_word(mpc)});
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2 rst = 1'b0;
    mq.delete();
    mpc = RPC0;
    @(negedge clk);
    check_model();
    chk("wrap_rst_addr", ifw.imem_addr_o, RPC1);
  endtask

  task automatic reset_mid_cycle();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'h0, ifb.if_valid_o}, 32'h0);
    chk("arst_instr", ifb.if_instr_o, 32'h0);
    chk("arst_pc", ifb.if_pc_o, 32'h0);
    chk("arst_addr", ifb.imem_addr_o, RPC0);
    chk("arst_wrap_addr", ifw.imem_addr_o, RPC1);
    release_rst();
  endtask

  initial begin
    logic [31:0] tgt;
    ifb.if_ready_i = 1'b1;  ifb.redirect_i = 1'b0;  ifb.redirect_pc_i = 32'h0;
    ifw.if_ready_i = 1'b1;  ifw.redirect_i = 1'b0;  ifw.redirect_pc_i = 32'h0;
    #3;
    chk("rst_valid", {31'h0, ifb.if_valid_o}, 32'h0);
    chk("rst_pc", ifb.if_pc_o, 32'h0);
    chk("rst_instr", ifb.if_instr_o, 32'h0);
    chk("rst_addr", ifb.imem_addr_o, RPC0);
    release_rst();

    // Streaming from reset, with the wrap-around instance alongside.
    step(1'b1, 1'b0, 32'h0);
    chk("s_pc0", ifb.if_pc_o, 32'h0);
    chk("s_in0", ifb.if_instr_o, 32'h0050_0093);
    chk("w_pc0", ifw.if_pc_o, 32'hFFFF_FFFC);
    chk("w_in0", ifw.if_instr_o, mem_word(32'hFFFF_FFFC));
    step(1'b1, 1'b0, 32'h0);
    chk("s_pc1", ifb.if_pc_o, 32'h4);
    chk("s_in1", ifb.if_instr_o, 32'h00A0_8113);
    chk("w_pc1", ifw.if_pc_o, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("s_pc2", ifb.if_pc_o, 32'h8);
    chk("s_in2", ifb.if_instr_o, 32'h0020_81B3);
    chk("w_pc2", ifw.if_pc_o, 32'h4);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

    // Backpressure from reset, then drain.
    ifb.if_ready_i = 1'b0;
    ifw.if_ready_i = 1'b0;
    reset_mid_cycle();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    chk("stall_addr", ifb.imem_addr_o, 32'h8);
    chk("stall_pc", ifb.if_pc_o, 32'h0);
    chk("stall_instr", ifb.if_instr_o, 32'h0050_0093);
    step(1'b1, 1'b0, 32'h0);
    chk("drain_pc1", ifb.if_pc_o, 32'h4);
    step(1'b1, 1'b0, 32'h0);
    chk("drain_pc2", ifb.if_pc_o, 32'h8);
    step(1'b1, 1'b0, 32'h0);
    chk("drain_pc3", ifb.if_pc_o, 32'hC);

    // Redirect while full.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h1C);
    chk("redir_valid", {31'h0, ifb.if_valid_o}, 32'h0);
    chk("redir_addr", ifb.imem_addr_o, 32'h1C);
    step(1'b1, 1'b0, 32'h0);
    chk("redir_pc", ifb.if_pc_o, 32'h1C);
    chk("redir_instr", ifb.if_instr_o, 32'h0002_8C63);

    // Misaligned redirect target.
    step(1'b1, 1'b1, 32'h1);
    chk("mis_addr", ifb.imem_addr_o, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("mis_pc", ifb.if_pc_o, 32'h0);
    chk("mis_instr", ifb.if_instr_o, 32'h0050_0093);

    // Back-to-back redirects: last target wins.
    step(1'b1, 1'b1, 32'h40);
    step(1'b1, 1'b1, 32'h80);
    step(1'b1, 1'b0, 32'h0);
    chk("b2b_pc", ifb.if_pc_o, 32'h80);

    for (int i = 0; i < 1500; i++) begin
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 255));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, tgt);
    end

    reset_mid_cycle();
    for (int i = 0; i < 20; i++) step($urandom_range(0, 1) == 1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch initiator that drives the instruction memory's combinational read port: presents a word address, captures the returned instruction, and advances the PC.
- Buffers fetched {pc, instr} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts a redirect from branch resolution (e.g. a taken beq), which flushes the buffer and restarts fetch at the target.
- Sits between the PC/branch logic and the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset; bits [1:0] are ignored and treated as 0.
- FIFO_DEPTH, 2, number of buffered fetch entries; must be a power of 2 and at least 2.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- imem_addr_o  output  32  fetch address to instruction memory; always equals pc_q.
- imem_instr_i  input  32  instruction word returned combinationally for imem_addr_o in the same cycle.
- redirect_i  input  1  branch/jump taken; flush and restart fetch.
- redirect_pc_i  input  32  redirect target; bits [1:0] are forced to 0.
- if_valid_o  output  1  FIFO head holds a valid instruction.
- if_ready_i  input  1  decode accepts the head this cycle.
- if_instr_o  output  32  instruction at the FIFO head.
- if_pc_o  output  32  PC of the FIFO head.

Behaviour:
Clock and reset:
- Single clock domain.
- rst_i asserts asynchronously and clears all state immediately: pc_q=RESET_PC&~3, count=0, read/write pointers=0, if_valid_o=0, if_instr_o=0, if_pc_o=0.
- Reset release is synchronous to clk_i (the bench releases it away from a clock edge).

Handshake:
- pop = if_valid_o & if_ready_i.
- push = !redirect_i & (count<FIFO_DEPTH | pop).
- Fetching while full is permitted when a pop happens in the same cycle.

Push:
- Writes {pc_q, imem_instr_i} at the write pointer.
- Updates pc_q <= pc_q + 32'd4, modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
- With no push, pc_q holds and imem_addr_o is stable.

Pop:
- Advances the read pointer.
- if_valid_o, if_instr_o and if_pc_o are driven from FIFO storage (registered, never combinational from imem_instr_i).
- When the FIFO is empty, if_instr_o=0 and if_pc_o=0.

Count:
- push&!pop: +1. pop&!push: -1. Both or neither: unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Latency:
- An instruction fetched in cycle N appears on if_*_o in cycle N+1.
- After reset release, the first valid (pc=RESET_PC) is in the second clock cycle.
- Sustained throughput with if_ready_i=1 is one instruction per cycle.

Backpressure:
- With if_ready_i=0, the FIFO fills in FIFO_DEPTH cycles, then fetch stalls with imem_addr_o = next unfetched PC.
- Head outputs hold stable while if_valid_o=1 and if_ready_i=0.

Redirect (highest priority):
- In the cycle redirect_i=1: no push, pop is ignored, count <= 0, both pointers <= 0, pc_q <= redirect_pc_i & ~32'h3.
- Next cycle: if_valid_o=0 and imem_addr_o=target; the target is fetched.
- The cycle after that: if_valid_o=1 with if_pc_o=target.
- Back-to-back redirects: the last one wins; nothing is pushed while redirect_i=1.

States:
- No explicit FSM. State is pc_q, count and pointers; EMPTY, PARTIAL and FULL are derived from count.

Test Plan:
- Memory preloaded: 0x00:00500093, 0x04:00A08113, 0x08:002081B3, 0x1C:00028C63. Release reset with if_ready_i=1 -> cycle 2: if_valid_o=1, pc 0x00, instr 00500093; cycle 3: pc 0x04, instr 00A08113; cycle 4: pc 0x08, instr 002081B3; one instruction per cycle thereafter.
- Hold if_ready_i=0 from reset -> FIFO full after 2 fetches, imem_addr_o stuck at 0x08, head stays pc 0x00 / 00500093. Raise if_ready_i -> outputs 0x00, 0x04, 0x08 in consecutive cycles with no gaps and no duplicates.
- Pulse redirect_i with redirect_pc_i=0x1C while the FIFO is full -> next cycle if_valid_o=0 and imem_addr_o=0x1C. Following cycle if_pc_o=0x1C, if_instr_o=00028C63. Entries fetched before the redirect are never presented.
- Redirect to 32'h00000001 -> fetch address 0x00000000; head shows pc 0x00, instr 00500093.
- Assert rst_i mid-stream, between clock edges -> if_valid_o, if_instr_o and if_pc_o go to 0 and imem_addr_o goes to RESET_PC before the next edge. Normal fetch resumes after release.
- Build with RESET_PC=32'hFFFFFFFC and if_ready_i=1 -> heads show pc FFFFFFFC then 00000000 (wrap), then 00000004.
